irq_entry_sequencer: RTL and testbench
======================================

Name: irq_entry_sequencer

Overview:
Interrupt controller and entry/exit sequencer that drives the banked-register interface of the core register file: int_mode select, irq_bak save codes and irq r0/r1 argument words.
- Arbitrates NUM_IRQ sources and captures the return PC into banked r14.
- Redirects fetch to a per-source vector, then holds interrupt mode until the core signals return.
- Sits between the peripheral IRQ lines and the register file / fetch PC mux, and advances on the same pipeline enable as the register file.

Parameters:
NUM_IRQ, 8, number of interrupt source lines (2..16)
VECTOR_BASE, 32'h0000_0018, address of vector for source 0; source n vectors to VECTOR_BASE + 4*n

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
en  input  1  pipeline advance enable (same signal as register file en)
i_irq  input  NUM_IRQ  interrupt request lines
i_irq_mask  input  NUM_IRQ  per-source enable, 1 = enabled
i_global_en  input  1  global interrupt enable (inverse of CPSR I bit)
i_pc_wr  input  1  PC write in flight this cycle (register file o_pc_en)
i_iret  input  1  return-from-interrupt strobe from decode
o_int_mode  output  1  select banked register set
o_irq_bak  output  2  bank save code to register file
o_irq_r0  output  32  zero-extended winning source id
o_irq_r1  output  32  zero-extended masked pending bitmap
o_pc_load  output  1  force fetch PC to o_pc_vector
o_pc_vector  output  32  vector address
o_irq_ack  output  NUM_IRQ  one-hot acknowledge of serviced source
o_busy  output  1  sequencer not in IDLE

Behaviour:
- Reset values: state IDLE; o_int_mode 0, o_irq_bak 00, o_irq_r0 0, o_irq_r1 0, o_pc_load 0, o_pc_vector VECTOR_BASE, o_irq_ack 0, o_busy 0. Reset mid-sequence aborts to IDLE immediately.
- Arbitration:
  - pend_m = pending & i_irq_mask.
  - Winner = lowest set index of pend_m.
  - Request valid = |pend_m & i_global_en.
- State transitions occur only on clk edges with en=1. With en=0, state, captured id and all outputs hold; o_pc_load and o_irq_ack are gated to 0 while en=0.
- IDLE:
  - Outputs: int_mode 0, bak 00. o_irq_r0/o_irq_r1 are combinational from the current winner/pend_m, so the register file banks r0/r1 every en-cycle, including the accept cycle.
  - Accept when en and request valid: capture the winner id and bitmap, go to CAPTURE.
- CAPTURE (1 en-cycle):
  - int_mode 0; bak = i_pc_wr ? 11 : 10. Code 10 saves pc_next into banked r14; code 11 saves the in-flight branch target.
  - o_irq_r0/r1 hold the captured values.
  - Next state ENTER.
- ENTER (1 en-cycle):
  - int_mode 1, bak 00 (ignored in int mode).
  - o_pc_load=1, o_pc_vector = VECTOR_BASE + (id<<2) (32-bit wrap), o_irq_ack = 1<<id.
  - Next state INT. i_iret is ignored in this state.
- INT:
  - int_mode 1, o_pc_load 0.
  - i_iret with en: next cycle IDLE (int_mode 0).
  - No nesting: new requests stay pending.
- o_busy = (state != IDLE).
- Pending without IRQ_EDGE_EN: pending = i_irq (level). The source must drop its request before iret, otherwise re-entry occurs immediately.
- Simultaneous i_iret and new request in INT: return first; the request is accepted from IDLE on a later en-cycle.

Optional Feature:
IRQ_EDGE_EN:
- Defined:
  - pending[i] register, set on a rising edge of i_irq[i] (sampled every clk, independent of en), cleared by o_irq_ack[i].
  - Set wins over clear in the same cycle.
  - Pending resets to 0.
- Undefined: level-sensitive, no pending storage.

Test Plan:
1. Assert and release rst_n with i_irq=0 -> all outputs at reset values; o_pc_vector=0x18; stays IDLE.
2. i_irq=0x08, mask=0xFF, global_en=1, en=1, i_pc_wr=0 -> accept cycle o_irq_r0=3, o_irq_r1=0x08; +1 bak=10; +2 int_mode=1, pc_load=1, vector=0x24, ack=0x08; i_iret -> next cycle int_mode=0, bak=00, busy=0.
3. i_irq=0x84 -> r0=2, r1=0x84, vector=0x20, ack=0x04.
4. Same as 2 with i_pc_wr=1 during CAPTURE -> o_irq_bak=11 for that cycle.
5. en=0 for 3 cycles while in CAPTURE -> bak held at 10, no transition, pc_load stays 0; en=1 -> ENTER next edge.
6. i_irq=0x01 with mask=0xFE or global_en=0 -> remains IDLE, r1=0, no ack. With IRQ_EDGE_EN: a 1-cycle pulse on irq[5] is serviced, ack clears pending.

Source files
------------

// File: rtl/irq_entry_sequencer.sv
// +----------------------------------------------------------------------------+
// | irq_entry_sequencer                                                        |
// | Interrupt arbiter and entry/exit sequencer for the banked register file.   |
// | Optional macro: IRQ_EDGE_EN (edge-triggered pending latches).              |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module irq_entry_sequencer #(
  parameter int          NUM_IRQ     = 8,
  parameter logic [31:0] VECTOR_BASE = 32'h0000_0018
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [NUM_IRQ-1:0] i_irq,
  input  logic [NUM_IRQ-1:0] i_irq_mask,
  input  logic               i_global_en,
  input  logic               i_pc_wr,
  input  logic               i_iret,
  output logic               o_int_mode,
  output logic [1:0]         o_irq_bak,
  output logic [31:0]        o_irq_r0,
  output logic [31:0]        o_irq_r1,
  output logic               o_pc_load,
  output logic [31:0]        o_pc_vector,
  output logic [NUM_IRQ-1:0] o_irq_ack,
  output logic               o_busy
);

  localparam int ID_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    ENTER   = 2'd2,
    INT     = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [NUM_IRQ-1:0] bitmap_q, bitmap_d;

  logic [NUM_IRQ-1:0] pending;
  logic [NUM_IRQ-1:0] pend_m;
  logic [ID_W-1:0]    win_id;
  logic               win_found;
  logic               req_valid;
  logic [NUM_IRQ-1:0] ack;

`ifdef IRQ_EDGE_EN
  logic [NUM_IRQ-1:0] irq_prev_q, irq_prev_d;
  logic [NUM_IRQ-1:0] pending_q, pending_d;

  // Rising edges are sampled every clock; a new edge outranks a same-cycle ack.
  always_comb begin
    irq_prev_d = i_irq;
    pending_d  = (pending_q & ~ack) | (i_irq & ~irq_prev_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_prev_q <= '0;
      pending_q  <= '0;
    end else begin
      irq_prev_q <= irq_prev_d;
      pending_q  <= pending_d;
    end
  end

  assign pending = pending_q;
`else
  assign pending = i_irq;
`endif

  assign pend_m    = pending & i_irq_mask;
  assign req_valid = (|pend_m) & i_global_en;

  // Fixed priority: lowest index wins.
  always_comb begin
    win_id    = '0;
    win_found = 1'b0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (pend_m[i] && !win_found) begin
        win_id    = ID_W'(i);
        win_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    bitmap_d = bitmap_q;
    if (en) begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            state_d  = CAPTURE;
            id_d     = win_id;
            bitmap_d = pend_m;
          end
        end
        CAPTURE: state_d = ENTER;
        ENTER:   state_d = INT;
        INT: begin
          if (i_iret) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      id_q     <= '0;
      bitmap_q <= '0;
    end else begin
      state_q  <= state_d;
      id_q     <= id_d;
      bitmap_q <= bitmap_d;
    end
  end

  assign ack = (en && state_q == ENTER) ? (NUM_IRQ'(1) << id_q) : '0;

  always_comb begin
    o_int_mode = 1'b0;
    o_irq_bak  = 2'b00;
    o_pc_load  = 1'b0;
    o_irq_r0   = {{(32-ID_W){1'b0}}, id_q};
    o_irq_r1   = {{(32-NUM_IRQ){1'b0}}, bitmap_q};
    case (state_q)
      IDLE: begin
        // Live arbitration result so r0/r1 are already banked on the accept cycle.
        o_irq_r0 = {{(32-ID_W){1'b0}}, win_id};
        o_irq_r1 = {{(32-NUM_IRQ){1'b0}}, pend_m};
      end
      CAPTURE: o_irq_bak = i_pc_wr ? 2'b11 : 2'b10;
      ENTER: begin
        o_int_mode = 1'b1;
        o_pc_load  = en;
      end
      INT:     o_int_mode = 1'b1;
      default: o_int_mode = 1'b0;
    endcase
  end

  assign o_pc_vector = VECTOR_BASE + {{(30-ID_W){1'b0}}, id_q, 2'b00};
  assign o_irq_ack   = ack;
  assign o_busy      = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_irq_entry_sequencer.sv
// +----------------------------------------------------------------------------+
// | tb_irq_entry_sequencer                                                     |
// | Directed self-checking bench for irq_entry_sequencer (NUM_IRQ = 8).        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_irq_entry_sequencer;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [7:0]  irq;
  logic [7:0]  irq_mask;
  logic        global_en;
  logic        pc_wr;
  logic        iret;
  logic        int_mode;
  logic [1:0]  irq_bak;
  logic [31:0] irq_r0;
  logic [31:0] irq_r1;
  logic        pc_load;
  logic [31:0] pc_vector;
  logic [7:0]  irq_ack;
  logic        busy;

  int errors = 0;
  int checks = 0;

  irq_entry_sequencer #(
    .NUM_IRQ    (8),
    .VECTOR_BASE(32'h0000_0018)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .i_irq      (irq),
    .i_irq_mask (irq_mask),
    .i_global_en(global_en),
    .i_pc_wr    (pc_wr),
    .i_iret     (iret),
    .o_int_mode (int_mode),
    .o_irq_bak  (irq_bak),
    .o_irq_r0   (irq_r0),
    .o_irq_r1   (irq_r1),
    .o_pc_load  (pc_load),
    .o_pc_vector(pc_vector),
    .o_irq_ack  (irq_ack),
    .o_busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge-mode pending registers need one extra clock after a request rises.
  task automatic settle_request();
`ifdef IRQ_EDGE_EN
    @(negedge clk);
`endif
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; irq = '0; irq_mask = 8'hFF; global_en = 1'b1;
    pc_wr = 1'b0; iret = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (int_mode !== 1'b0) begin errors++; $display("FAIL reset_int_mode got=%0b exp=0", int_mode); end
    checks++; if (irq_bak !== 2'b00) begin errors++; $display("FAIL reset_bak got=%b exp=00", irq_bak); end
    checks++; if (irq_r0 !== 32'd0 || irq_r1 !== 32'd0) begin errors++; $display("FAIL reset_r0r1 got=%h/%h exp=0/0", irq_r0, irq_r1); end
    checks++; if (pc_load !== 1'b0 || irq_ack !== 8'h00) begin errors++; $display("FAIL reset_load_ack got=%b/%h exp=0/00", pc_load, irq_ack); end
    checks++; if (pc_vector !== 32'h18) begin errors++; $display("FAIL reset_vector got=%h exp=00000018", pc_vector); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle got=%0b exp=0", busy); end
  endtask

  // Full entry/exit sequence with expected id, bitmap, bank code and vector.
  task automatic run_entry(input string tag, input logic [7:0] req, input logic wr,
                           input logic [31:0] exp_id, input logic [31:0] exp_vec,
                           input logic [7:0] exp_ack);
    irq = req; pc_wr = 1'b0;
    settle_request();
    checks++; if (irq_r0 !== exp_id || irq_r1 !== {24'd0, req}) begin errors++; $display("FAIL %s_accept_r0r1 got=%h/%h exp=%h/%h", tag, irq_r0, irq_r1, exp_id, {24'd0, req}); end
    @(negedge clk);
    pc_wr = wr; #1;
    checks++; if (irq_bak !== (wr ? 2'b11 : 2'b10) || int_mode !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL %s_capture got bak=%b mode=%0b busy=%0b exp bak=%b mode=0 busy=1", tag, irq_bak, int_mode, busy, wr ? 2'b11 : 2'b10); end
    checks++; if (irq_r0 !== exp_id) begin errors++; $display("FAIL %s_capture_r0 got=%h exp=%h", tag, irq_r0, exp_id); end
    @(negedge clk);
    pc_wr = 1'b0;
    checks++; if (int_mode !== 1'b1 || pc_load !== 1'b1 || irq_bak !== 2'b00) begin errors++; $display("FAIL %s_enter got mode=%0b load=%0b bak=%b exp 1/1/00", tag, int_mode, pc_load, irq_bak); end
    checks++; if (pc_vector !== exp_vec || irq_ack !== exp_ack) begin errors++; $display("FAIL %s_enter_vec_ack got=%h/%h exp=%h/%h", tag, pc_vector, irq_ack, exp_vec, exp_ack); end
    irq = '0;
    @(negedge clk);
    checks++; if (int_mode !== 1'b1 || pc_load !== 1'b0 || irq_ack !== 8'h00) begin errors++; $display("FAIL %s_int got mode=%0b load=%0b ack=%h exp 1/0/00", tag, int_mode, pc_load, irq_ack); end
    iret = 1'b1;
    @(negedge clk);
    iret = 1'b0;
    checks++; if (int_mode !== 1'b0 || irq_bak !== 2'b00 || busy !== 1'b0) begin errors++; $display("FAIL %s_return got mode=%0b bak=%b busy=%0b exp 0/00/0", tag, int_mode, irq_bak, busy); end
  endtask

  task automatic test_basic_entry();
    run_entry("src3", 8'h08, 1'b0, 32'd3, 32'h24, 8'h08);
  endtask

  task automatic test_priority();
    run_entry("src2", 8'h84, 1'b0, 32'd2, 32'h20, 8'h04);
  endtask

  task automatic test_branch_bank();
    run_entry("pcwr", 8'h08, 1'b1, 32'd3, 32'h24, 8'h08);
  endtask

  task automatic test_top_source();
    run_entry("src7", 8'h80, 1'b0, 32'd7, 32'h34, 8'h80);
  endtask

  task automatic test_stall();
    irq = 8'h02;
    settle_request();
    @(negedge clk);
    en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if (irq_bak !== 2'b10 || int_mode !== 1'b0 || pc_load !== 1'b0 || irq_ack !== 8'h00) begin errors++; $display("FAIL stall_hold%0d got bak=%b mode=%0b load=%0b ack=%h exp 10/0/0/00", k, irq_bak, int_mode, pc_load, irq_ack); end
    end
    en = 1'b1;
    @(negedge clk);
    checks++; if (pc_load !== 1'b1 || pc_vector !== 32'h1C || irq_ack !== 8'h02) begin errors++; $display("FAIL stall_enter got load=%0b vec=%h ack=%h exp 1/0000001c/02", pc_load, pc_vector, irq_ack); end
    en = 1'b0; #1;
    checks++; if (pc_load !== 1'b0 || irq_ack !== 8'h00) begin errors++; $display("FAIL stall_gate got load=%0b ack=%h exp 0/00", pc_load, irq_ack); end
    en = 1'b1; irq = '0;
    @(negedge clk);
    iret = 1'b1;
    @(negedge clk);
    iret = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stall_exit got busy=%0b exp 0", busy); end
  endtask

  task automatic test_no_nest();
    irq = 8'h10;
    settle_request();
    repeat (3) @(negedge clk);
    irq = 8'h11;
    iret = 1'b1;
    @(negedge clk);
    iret = 1'b0;
    irq = 8'h01; #1;
    checks++; if (busy !== 1'b0 || int_mode !== 1'b0) begin errors++; $display("FAIL iret_first got busy=%0b mode=%0b exp 0/0", busy, int_mode); end
    @(negedge clk);
    checks++; if (busy !== 1'b1 || irq_r0 !== 32'd0) begin errors++; $display("FAIL reaccept got busy=%0b r0=%h exp 1/0", busy, irq_r0); end
    irq = '0;
    repeat (2) @(negedge clk);
    iret = 1'b1;
    @(negedge clk);
    iret = 1'b0;
  endtask

  task automatic test_masked();
    irq = 8'h01; irq_mask = 8'hFE;
    settle_request();
    checks++; if (irq_r1 !== 32'd0) begin errors++; $display("FAIL mask_r1 got=%h exp=0", irq_r1); end
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0 || irq_ack !== 8'h00) begin errors++; $display("FAIL mask_idle got busy=%0b ack=%h exp 0/00", busy, irq_ack); end
    irq_mask = 8'hFF; global_en = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0 || irq_ack !== 8'h00 || pc_load !== 1'b0) begin errors++; $display("FAIL gdis_idle got busy=%0b ack=%h load=%0b exp 0/00/0", busy, irq_ack, pc_load); end
    irq = '0; global_en = 1'b1;
  endtask

  task automatic test_reset_abort();
    irq = 8'h40;
    settle_request();
    @(negedge clk);
    rst_n = 1'b0; #1;
    checks++; if (busy !== 1'b0 || irq_bak !== 2'b00 || pc_vector !== 32'h18) begin errors++; $display("FAIL abort got busy=%0b bak=%b vec=%h exp 0/00/00000018", busy, irq_bak, pc_vector); end
    irq = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

`ifdef IRQ_EDGE_EN
  task automatic test_edge_pulse();
    irq_mask = 8'h20;
    @(negedge clk);
    irq = 8'h20;
    @(negedge clk);
    irq = 8'h00; #1;
    checks++; if (irq_r0 !== 32'd5 || irq_r1 !== 32'h20) begin errors++; $display("FAIL edge_pending got=%h/%h exp=5/20", irq_r0, irq_r1); end
    repeat (2) @(negedge clk);
    checks++; if (irq_ack !== 8'h20 || pc_vector !== 32'h2C) begin errors++; $display("FAIL edge_ack got=%h/%h exp=20/0000002c", irq_ack, pc_vector); end
    @(negedge clk);
    iret = 1'b1;
    @(negedge clk);
    iret = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || irq_r1 !== 32'd0) begin errors++; $display("FAIL edge_cleared got busy=%0b r1=%h exp 0/0", busy, irq_r1); end
    irq_mask = 8'hFF;
  endtask
`endif

  initial begin
    test_reset();
    test_basic_entry();
    test_priority();
    test_branch_bank();
    test_top_source();
    test_stall();
    test_no_nest();
    test_reset_abort();
    test_masked();
`ifdef IRQ_EDGE_EN
    test_edge_pulse();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout reached");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
